// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test initiator for a synchronous single-port RAM.
// Runs a two-pass march: write the whole array, then read back and compare.
// Pass 0 writes seed ^ {a,a}; pass 1 writes the complement. The first
// miscompare ends the run early, recording its address and data.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, seed        launch request (sampled in IDLE) and pattern seed
//   busy, done, pass   run in progress, one-cycle completion pulse, result
//   fail_addr/data     first miscompare address and the data read there
//   ram_rst            RAM synchronous clear (combinational ~rst_n)
//   ram_we/addr/din    RAM control and write data (registered)
//   ram_dout           RAM registered read data
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              ram_rst,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_TAIL,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  function automatic logic [DATA_W-1:0] pattern(
    input logic [DATA_W-1:0] s,
    input logic [ADDR_W-1:0] a,
    input logic              inv
  );
    logic [DATA_W-1:0] p;
    p = s ^ {a, a};
    return inv ? ~p : p;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pass_sel_q, pass_sel_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  // One-cycle delayed read address/valid, aligned with the RAM's registered dout.
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mismatch;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pass_sel_d  = pass_sel_q;
    seed_d      = seed_q;
    vld_d       = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    mismatch = vld_q && (ram_dout != pattern(seed_q, cmp_addr_q, pass_sel_q));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR;
          seed_d      = seed;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_sel_d  = 1'b0;
          cnt_d       = '0;
        end
      end
      S_WR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD: begin
        vld_d      = 1'b1;
        cmp_addr_d = cnt_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_TAIL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (!pass_sel_q) begin
          state_d    = S_WR;
          pass_sel_d = 1'b1;
          cnt_d      = '0;
        end else begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A miscompare overrides whatever RD/TAIL decided and ends the run.
    if (mismatch) begin
      state_d     = S_DONE;
      pass_d      = 1'b0;
      fail_addr_d = cmp_addr_q;
      fail_data_d = ram_dout;
      vld_d       = 1'b0;
    end

    // Outputs are registered, so they are derived from the next state.
    ram_we_d   = (state_d == S_WR);
    ram_addr_d = (state_d == S_WR || state_d == S_RD) ? cnt_d : '0;
    ram_din_d  = (state_d == S_WR) ? pattern(seed_d, cnt_d, pass_sel_d) : '0;
    busy_d     = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_TAIL);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pass_sel_q  <= 1'b0;
      seed_q      <= '0;
      vld_q       <= 1'b0;
      cmp_addr_q  <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pass_sel_q  <= pass_sel_d;
      seed_q      <= seed_d;
      vld_q       <= vld_d;
      cmp_addr_q  <= cmp_addr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_rst   = ~rst_n;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl: behavioural RAM with stuck-at fault masks,
// a scoreboard of expected RAM writes and run results, and a monitor that
// checks them whenever the DUT writes or pulses done.
module tb_ram_bist_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  typedef struct {
    int          cyc;
    logic [3:0]  addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int          done_cyc;
    int          busy_len;
    logic        pass;
    logic [3:0]  fa;
    logic [7:0]  fd;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] seed_in = '0;
  logic          busy, done, pass, ram_rst, ram_we;
  logic [AW-1:0] fail_addr, ram_addr;
  logic [DW-1:0] fail_data, ram_din, ram_dout;
  logic [DW-1:0] dout_raw;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] m0 = '0;
  logic [DW-1:0] m1 = '0;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int busy_cnt = 0;

  wr_t  wr_q[$];
  res_t res_q[$];

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram_rst   (ram_rst),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 16x8 RAM: sync clear, write-through-hold dout, registered read.
  always @(posedge clk) begin
    if (ram_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout_raw <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end else begin
      dout_raw <= mem[ram_addr];
    end
  end

  // Stuck-at-0 bits (m0) and stuck-at-1 bits (m1) on the read port.
  assign ram_dout = (dout_raw & ~m0) | m1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: enumerate the march in plain loops and predict every
  // write (cycle, addr, data) and the run outcome.
  task automatic push_run(input int base, input logic [7:0] s,
                          input logic [7:0] k0, input logic [7:0] k1);
    res_t       r;
    wr_t        w;
    logic [7:0] d;
    logic [7:0] rd;
    logic [3:0] a4;
    bit         failed;
    failed     = 0;
    r.pass     = 1'b1;
    r.fa       = '0;
    r.fd       = '0;
    r.done_cyc = base + 66;
    for (int p = 0; p < 2 && !failed; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        a4 = 4'(a);
        d  = s ^ {a4, a4};
        if (p == 1) d = ~d;
        w.cyc  = base + 33 * p + a;
        w.addr = a4;
        w.data = d;
        wr_q.push_back(w);
      end
      for (int a = 0; a < DEPTH && !failed; a++) begin
        a4 = 4'(a);
        d  = s ^ {a4, a4};
        if (p == 1) d = ~d;
        rd = (d & ~k0) | k1;
        if (rd != d) begin
          failed     = 1;
          r.pass     = 1'b0;
          r.fa       = a4;
          r.fd       = rd;
          r.done_cyc = base + 33 * p + 17 + a + 1;
        end
      end
    end
    r.busy_len = r.done_cyc - base;
    res_q.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT writes or signals done.
  initial begin
    wr_t  e;
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (ram_we) begin
          if (wr_q.size() == 0) begin
            chk("write_expected", 64'(wr_q.size()), 64'd1);
          end else begin
            e = wr_q.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            chk("wr_addr", 64'(ram_addr), 64'(e.addr));
            chk("wr_data", 64'(ram_din), 64'(e.data));
          end
        end
        if (busy) busy_cnt++;
        if (done) begin
          if (res_q.size() == 0) begin
            chk("done_expected", 64'(res_q.size()), 64'd1);
          end else begin
            r = res_q.pop_front();
            chk("done_cycle", 64'(cyc), 64'(r.done_cyc));
            chk("busy_len", 64'(busy_cnt), 64'(r.busy_len));
            chk("pass", 64'(pass), 64'(r.pass));
            chk("fail_addr", 64'(fail_addr), 64'(r.fa));
            chk("fail_data", 64'(fail_data), 64'(r.fd));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic wait_complete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_q.size() == 0) break;
    end
    chk("run_complete", 64'(res_q.size()), 64'd0);
    chk("writes_drained", 64'(wr_q.size()), 64'd0);
    res_q.delete();
    wr_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // Called just after a negedge: drops reset mid-clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    res_q.delete();
    wr_q.delete();
    #1;
    chk("rst_outputs", 64'({busy, done, pass, fail_addr, fail_data, ram_we, ram_addr, ram_din}), 64'd0);
    chk("rst_ram_rst", 64'(ram_rst), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", 64'(busy), 64'd0);
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] k0, input logic [7:0] k1,
                     input bit pulse10, input bit abort20);
    int base;
    @(negedge clk);
    seed_in = s;
    m0      = k0;
    m1      = k1;
    start   = 1'b1;
    base    = cyc + 1;
    push_run(base, s, k0, k1);
    @(negedge clk);
    start   = 1'b0;
    seed_in = 8'($urandom);
    if (pulse10) begin
      while (cyc < base + 10) @(negedge clk);
      start   = 1'b1;
      seed_in = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    if (abort20) begin
      while (cyc < base + 20) @(negedge clk);
      do_reset();
    end else begin
      wait_complete();
    end
  endtask

  // start held high: second run launches from the IDLE cycle after DONE.
  task automatic run_hold(input logic [7:0] s, input logic [7:0] s2);
    int base;
    @(negedge clk);
    seed_in = s;
    m0      = '0;
    m1      = '0;
    start   = 1'b1;
    base    = cyc + 1;
    push_run(base, s, 8'h00, 8'h00);
    push_run(base + 68, s2, 8'h00, 8'h00);
    @(negedge clk);
    seed_in = s2;
    while (cyc < base + 67) @(negedge clk);
    chk("hold_idle_busy", 64'(busy), 64'd0);
    chk("hold_idle_pass", 64'(pass), 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("hold_relaunch_busy", 64'(busy), 64'd1);
    chk("hold_relaunch_pass", 64'(pass), 64'd0);
    wait_complete();
  endtask

  initial begin
    logic [7:0] rs, k0, k1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("por_outputs", 64'({busy, done, pass, fail_addr, fail_data, ram_we, ram_addr, ram_din}), 64'd0);
    chk("por_ram_rst", 64'(ram_rst), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_release_busy", 64'(busy), 64'd0);

    run(8'h00, 8'h00, 8'h00, 0, 0);
    run(8'hA5, 8'h00, 8'h00, 0, 0);
    run(8'h00, 8'h01, 8'h00, 0, 0);
    run(8'h3C, 8'h00, 8'h00, 1, 0);
    run(8'h5A, 8'h00, 8'h00, 0, 1);
    run(8'h5A, 8'h00, 8'h00, 0, 0);
    run_hold(8'h00, 8'hC3);

    for (int i = 0; i < 8; i++) begin
      rs = 8'($urandom);
      k0 = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      k1 = ($urandom_range(0, 2) == 2) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run(rs, k0, k1, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
